// File: rtl/occ_storage_arbiter.sv
// Four-lane read-request responder: latches one-cycle strobes per lane, arbitrates them
// round-robin onto a single synchronous-read storage port and routes the data back.
module occ_storage_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              storage_ce_1,
    input  logic              storage_ce_2,
    input  logic              storage_ce_3,
    input  logic              storage_ce_4,
    input  logic [ADDR_W-1:0] storage_addr_1,
    input  logic [ADDR_W-1:0] storage_addr_2,
    input  logic [ADDR_W-1:0] storage_addr_3,
    input  logic [ADDR_W-1:0] storage_addr_4,
    output logic [DATA_W-1:0] data_to_alu_1,
    output logic [DATA_W-1:0] data_to_alu_2,
    output logic [DATA_W-1:0] data_to_alu_3,
    output logic [DATA_W-1:0] data_to_alu_4,
    output logic              done_1,
    output logic              done_2,
    output logic              done_3,
    output logic              done_4,
    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [3:0]        ce;
    logic [ADDR_W-1:0] addr_in [4];

    logic [3:0]        pend_q;
    logic [ADDR_W-1:0] addr_q [4];
    logic [1:0]        last_q;
    logic              inflight_v_q;
    logic [3:0]        inflight_tag_q;
    logic [DATA_W-1:0] data_q [4];
    logic [3:0]        done_q;

    logic [3:0]        gnt;
    logic [1:0]        gnt_idx;
    logic [1:0]        search_idx;

    assign ce         = {storage_ce_4, storage_ce_3, storage_ce_2, storage_ce_1};
    assign addr_in[0] = storage_addr_1;
    assign addr_in[1] = storage_addr_2;
    assign addr_in[2] = storage_addr_3;
    assign addr_in[3] = storage_addr_4;

    // Search begins one past the last granted lane; i=4 wraps back onto the last lane itself.
    always_comb begin
        gnt        = '0;
        gnt_idx    = last_q;
        search_idx = last_q;
        for (int i = 1; i <= 4; i++) begin
            search_idx = last_q + 2'(i);
            if (pend_q[search_idx] && (gnt == 4'b0000)) begin
                gnt[search_idx] = 1'b1;
                gnt_idx         = search_idx;
            end
        end
    end

    assign mem_ce   = |pend_q;
    assign mem_addr = mem_ce ? addr_q[gnt_idx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q         <= '0;
            last_q         <= 2'd3;
            inflight_v_q   <= 1'b0;
            inflight_tag_q <= '0;
            done_q         <= '0;
            for (int i = 0; i < 4; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                // A strobe on a busy, ungranted lane is a protocol violation and is dropped.
                if (ce[i] && (!pend_q[i] || gnt[i])) begin
                    pend_q[i] <= 1'b1;
                    addr_q[i] <= addr_in[i];
                end else if (gnt[i]) begin
                    pend_q[i] <= 1'b0;
                end
                if (inflight_v_q && inflight_tag_q[i]) begin
                    data_q[i] <= mem_rdata;
                end
            end
            if (|gnt) begin
                last_q <= gnt_idx;
            end
            inflight_v_q   <= |gnt;
            inflight_tag_q <= gnt;
            done_q         <= inflight_v_q ? inflight_tag_q : 4'b0000;
        end
    end

    assign data_to_alu_1 = data_q[0];
    assign data_to_alu_2 = data_q[1];
    assign data_to_alu_3 = data_q[2];
    assign data_to_alu_4 = data_q[3];
    assign done_1        = done_q[0];
    assign done_2        = done_q[1];
    assign done_3        = done_q[2];
    assign done_4        = done_q[3];

endmodule

// File: tb/tb_occ_storage_arbiter.sv
// Scoreboard bench for occ_storage_arbiter: directed requests push expected (lane, data, cycle)
// entries; a negedge monitor pops and compares on every done pulse.
module tb_occ_storage_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ce;
    logic [7:0]  addr [4];
    logic [31:0] data [4];
    logic [3:0]  done;
    logic        mem_ce;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    occ_storage_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .storage_ce_1  (ce[0]),
        .storage_ce_2  (ce[1]),
        .storage_ce_3  (ce[2]),
        .storage_ce_4  (ce[3]),
        .storage_addr_1(addr[0]),
        .storage_addr_2(addr[1]),
        .storage_addr_3(addr[2]),
        .storage_addr_4(addr[3]),
        .data_to_alu_1 (data[0]),
        .data_to_alu_2 (data[1]),
        .data_to_alu_3 (data[2]),
        .data_to_alu_4 (data[3]),
        .done_1        (done[0]),
        .done_2        (done[1]),
        .done_3        (done[2]),
        .done_4        (done[3]),
        .mem_ce        (mem_ce),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata)
    );

    // Storage model: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (mem_ce) mem_rdata <= 32'hA5A5_0000 | {24'h0, mem_addr};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int mem_cnt = 0;
    always @(negedge clk) begin
        if (mem_ce === 1'b1) mem_cnt <= mem_cnt + 1;
    end

    typedef struct {
        int          lane;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int mon_tests = 0, mon_fails = 0;
    int seq_tests = 0, seq_fails = 0;

    task automatic mon_check(input string name, input logic [31:0] act, input logic [31:0] req);
        mon_tests++;
        if (act !== req) begin
            mon_fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic seq_check(input string name, input logic [31:0] act, input logic [31:0] req);
        seq_tests++;
        if (act !== req) begin
            seq_fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (done[i] === 1'b1) begin
                    if (sb.size() == 0) begin
                        mon_check("unexpected_done_lane", 32'(i + 1), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        mon_check("done_lane", 32'(i + 1), 32'(e.lane + 1));
                        mon_check("done_data", data[i], e.data);
                        mon_check("done_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    task automatic push(input int lane, input logic [7:0] a, input int c);
        exp_t x;
        x.lane = lane;
        x.data = 32'hA5A5_0000 | {24'h0, a};
        x.cyc  = c;
        sb.push_back(x);
    endtask

    // Called #1 after a rising edge; holds the strobes for exactly one cycle.
    task automatic drive(input logic [3:0] lanes, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3);
        ce      = lanes;
        addr[0] = a0;
        addr[1] = a1;
        addr[2] = a2;
        addr[3] = a3;
        @(posedge clk);
        #1;
        ce = 4'b0000;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    int k;
    int base;

    initial begin
        rst = 1'b1;
        ce  = 4'b0000;
        for (int i = 0; i < 4; i++) addr[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        seq_check("rst_mem_ce", 32'(mem_ce), 32'(0));
        seq_check("rst_mem_addr", 32'(mem_addr), 32'(0));
        seq_check("rst_done", 32'(done), 32'(0));
        seq_check("rst_data1", data[0], 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All four lanes at once from reset order: 1,2,3,4.
        k    = cyc;
        base = mem_cnt;
        push(0, 8'h01, k + 3);
        push(1, 8'h02, k + 4);
        push(2, 8'h03, k + 5);
        push(3, 8'h04, k + 6);
        drive(4'hF, 8'h01, 8'h02, 8'h03, 8'h04);
        wait_cyc(k + 8);
        seq_check("mem_ce_cycles", 32'(mem_cnt - base), 32'(4));

        // Single request, lane 1.
        k = cyc;
        push(0, 8'h12, k + 3);
        drive(4'h1, 8'h12, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        seq_check("single_mem_ce", 32'(mem_ce), 32'(1));
        seq_check("single_mem_addr", 32'(mem_addr), 32'h12);
        wait_cyc(k + 6);

        // Lane 2 becomes last grant, then all four: order 3,4,1,2.
        k = cyc;
        push(1, 8'h2A, k + 3);
        drive(4'h2, 8'h00, 8'h2A, 8'h00, 8'h00);
        wait_cyc(k + 6);
        k = cyc;
        push(2, 8'h03, k + 3);
        push(3, 8'h04, k + 4);
        push(0, 8'h01, k + 5);
        push(1, 8'h02, k + 6);
        drive(4'hF, 8'h01, 8'h02, 8'h03, 8'h04);
        wait_cyc(k + 9);

        // Lane 4 re-strobes while pending and not granted (lane 3 wins that cycle).
        k = cyc;
        push(2, 8'h33, k + 3);
        push(3, 8'h40, k + 4);
        push(0, 8'h31, k + 5);
        push(1, 8'h32, k + 6);
        drive(4'hF, 8'h31, 8'h32, 8'h33, 8'h40);
        drive(4'h8, 8'h31, 8'h32, 8'h33, 8'h41);
        wait_cyc(k + 9);

        // Lane 1 re-requests in its own done cycle.
        k = cyc;
        push(0, 8'h50, k + 3);
        push(0, 8'h22, k + 6);
        drive(4'h1, 8'h50, 8'h00, 8'h00, 8'h00);
        wait_cyc(k + 3);
        drive(4'h1, 8'h22, 8'h00, 8'h00, 8'h00);
        wait_cyc(k + 9);

        // Reset one cycle after three lanes request: everything is discarded.
        drive(4'h7, 8'h61, 8'h62, 8'h63, 8'h00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        seq_check("midrst_mem_ce", 32'(mem_ce), 32'(0));
        seq_check("midrst_mem_addr", 32'(mem_addr), 32'(0));
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        seq_check("post_rst_mem_ce", 32'(mem_ce), 32'(0));
        seq_check("post_rst_done", 32'(done), 32'(0));
        seq_check("post_rst_data1", data[0], 32'h0);
        seq_check("post_rst_data2", data[1], 32'h0);
        seq_check("post_rst_data3", data[2], 32'h0);
        seq_check("post_rst_data4", data[3], 32'h0);

        seq_check("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", mon_tests + seq_tests, mon_fails + seq_fails);
        $finish;
    end

endmodule
